// File: rtl/scr_pkg.sv
// scr_pkg: shared widths and FSM state type for the scratch RAM arbiter.
package scr_pkg;
    localparam int SCR_ADDR_W = 8;
    localparam int SCR_DATA_W = 10;
    typedef enum logic [0:0] {CLEAR = 1'b0, RUN = 1'b1} scr_state_t;
endpackage

// File: rtl/scr_clear_seq.sv
// scr_clear_seq: address counter for the post-reset zero fill, flags the last word.
module scr_clear_seq
    import scr_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    output logic [SCR_ADDR_W-1:0] addr,
    output logic                  done
);
    always_ff @(posedge clk) begin
        if (rst) addr <= '0;
        else if (en) addr <= addr + 1'b1;
    end
    assign done = en && (&addr);
endmodule

// File: rtl/scr_arbiter.sv
// scr_arbiter: CPU/DMA arbiter for a scratch RAM with DMA starvation guard
// and an optional zero fill after reset.
module scr_arbiter
    import scr_pkg::*;
#(
    parameter int STARVE_MAX     = 4,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  RST,
    input  logic                  CPU_REQ,
    input  logic                  CPU_WE,
    input  logic [SCR_ADDR_W-1:0] CPU_ADDR,
    input  logic [SCR_DATA_W-1:0] CPU_DIN,
    output logic                  CPU_GNT,
    output logic [SCR_DATA_W-1:0] CPU_DOUT,
    input  logic                  DMA_REQ,
    input  logic                  DMA_WE,
    input  logic [SCR_ADDR_W-1:0] DMA_ADDR,
    input  logic [SCR_DATA_W-1:0] DMA_DIN,
    output logic                  DMA_GNT,
    output logic [SCR_DATA_W-1:0] DMA_DOUT,
    output logic [SCR_ADDR_W-1:0] SCR_ADDR,
    output logic                  SCR_WE,
    output logic [SCR_DATA_W-1:0] DATA_IN,
    input  logic [SCR_DATA_W-1:0] DATA_OUT,
    output logic                  BUSY
);
    localparam int SW = $clog2(STARVE_MAX + 1);

    scr_state_t            state;
    logic [SW-1:0]         starve_cnt;
    logic [SCR_ADDR_W-1:0] clr_addr;
    logic                  clr_done;
    logic                  clearing;
    logic                  running;

    // Outputs are gated by RST so an access in flight during reset never writes.
    assign clearing = !RST && state == CLEAR;
    assign running  = !RST && state == RUN;
    assign DMA_GNT  = running && DMA_REQ && (!CPU_REQ || starve_cnt == SW'(STARVE_MAX));
    assign CPU_GNT  = running && CPU_REQ && !DMA_GNT;
    assign BUSY     = clearing;
    assign SCR_WE   = clearing || (CPU_GNT && CPU_WE) || (DMA_GNT && DMA_WE);
    assign SCR_ADDR = clearing ? clr_addr : CPU_GNT ? CPU_ADDR : DMA_GNT ? DMA_ADDR : '0;
    assign DATA_IN  = CPU_GNT ? CPU_DIN : DMA_GNT ? DMA_DIN : '0;
    assign CPU_DOUT = CPU_GNT ? DATA_OUT : '0;
    assign DMA_DOUT = DMA_GNT ? DATA_OUT : '0;

    scr_clear_seq u_clear (
        .clk  (clk),
        .rst  (RST),
        .en   (clearing),
        .addr (clr_addr),
        .done (clr_done)
    );

    always_ff @(posedge clk) begin
        if (RST) begin
            state      <= CLEAR_ON_RESET ? CLEAR : RUN;
            starve_cnt <= '0;
        end else begin
            if (clr_done) state <= RUN;
            starve_cnt <= (running && DMA_REQ && !DMA_GNT)
                        ? (starve_cnt == SW'(STARVE_MAX) ? starve_cnt : starve_cnt + 1'b1)
                        : '0;
        end
    end
endmodule

// File: doc/scr_arbiter.md
SCR_ARBITER -- requirements
Module: scr_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 4: consecutive denied DMA cycles before DMA is forced a slot.
REQ-002 Parameter CLEAR_ON_RESET, default 1: 1 = zero-fill the scratch RAM after reset; 0 = skip the fill.
REQ-003 Port clk  in  1  system clock; all state updates on the rising edge.
REQ-004 Port RST  in  1  reset; synchronous and active-high.
REQ-005 Ports CPU_REQ / CPU_WE  in  1 each  CPU access request / write enable.
REQ-006 Ports CPU_ADDR  in  8 and CPU_DIN  in  10  CPU address / write data.
REQ-007 Ports CPU_GNT  out  1 and CPU_DOUT  out  10  CPU grant / read data.
REQ-008 Ports DMA_REQ, DMA_WE, DMA_ADDR, DMA_DIN, DMA_GNT, DMA_DOUT  same directions and widths as the CPU set  secondary requester.
REQ-009 Ports SCR_ADDR  out  8, SCR_WE  out  1, DATA_IN  out  10  drive the scratch RAM.
REQ-010 Port DATA_OUT  in  10  scratch RAM combinational read data.
REQ-011 Port BUSY  out  1  high while the clear sequence runs.

Function
REQ-012 The FSM SHALL have two states, CLEAR and RUN; reset enters CLEAR if CLEAR_ON_RESET=1, otherwise RUN.
REQ-013 In CLEAR: SCR_WE=1, DATA_IN=0, SCR_ADDR=clear counter (0..255, +1 per cycle); both grants 0; BUSY=1.
REQ-014 CLEAR SHALL last exactly 256 cycles; the cycle that writes address 255 moves the FSM to RUN; the counter wraps to 0.
REQ-015 In RUN: at most one requester is granted per cycle, and grant is combinational from the current requests and the starvation count.
REQ-016 Arbitration: CPU_REQ alone grants CPU; DMA_REQ alone grants DMA.
REQ-017 With both requests, CPU wins unless starve_cnt == STARVE_MAX; then DMA wins.
REQ-018 starve_cnt SHALL increment each cycle DMA_REQ=1 and DMA_GNT=0, saturating at STARVE_MAX.
REQ-019 starve_cnt SHALL clear to 0 when DMA is granted or when DMA_REQ=0.
REQ-020 Granted requester: SCR_ADDR/DATA_IN/SCR_WE driven from its ADDR/DIN/WE; its DOUT = DATA_OUT in the same cycle (zero-latency read); a write commits at the next clk edge.
REQ-021 Ungranted requester: DOUT=0. No grant: SCR_WE=0, SCR_ADDR=0, DATA_IN=0.
REQ-022 SCR_WE SHALL never be 1 except from CLEAR or a granted requester with WE=1.
REQ-023 Requests during CLEAR SHALL be ignored (not queued); requesters hold REQ until GNT is seen.

Reset
REQ-024 While RST=1 at a clock edge: all grants 0, SCR_WE=0, BUSY=0, starve_cnt=0, clear counter=0.
REQ-025 Next state after reset SHALL follow REQ-012.
REQ-026 RST asserted mid-CLEAR SHALL restart the fill at address 0.
REQ-027 RST asserted mid-access SHALL suppress that write.

Structure
REQ-028 Package scr_pkg SHALL hold SCR_ADDR_W=8, SCR_DATA_W=10 and the enum scr_state_t {CLEAR, RUN}.
REQ-029 The clear counter and its done flag SHALL be one sub-module, scr_clear_seq; arbitration stays in scr_arbiter.

Verification
REQ-030 RST 1 cycle, then idle -> BUSY=1 for exactly 256 cycles, SCR_WE=1 with addresses 0..255, DATA_IN=0; then BUSY=0 and every RAM word reads 0.
REQ-031 RUN, CPU writes 0x3A5 to addr 0x10, then reads addr 0x10 -> CPU_GNT=1 both cycles; CPU_DOUT=0x3A5 on the read cycle.
REQ-032 RUN, CPU_REQ and DMA_REQ held high continuously -> grant pattern CPU x4, DMA x1, repeating; starve_cnt returns to 0 after each DMA grant.
REQ-033 CPU_REQ and DMA_REQ both high during CLEAR -> grants stay 0; the first grant appears on the first RUN cycle and goes to CPU.
REQ-034 RST at clear address 100 -> next fill restarts at address 0 and takes 256 full cycles.
REQ-035 DMA write of 0x2FF to addr 0xFF granted, RST asserted in the same cycle -> addr 0xFF keeps its previous value.
